// File: rtl/car_dash_pkg.sv
// rtl/car_dash_pkg.sv - shared types, constants and wall-mask helper for the obstacle generator
//
// Purpose : FSM state encoding, Galois LFSR feedback mask and a helper that
//           builds the walls-only pattern (bits 0 and seg_w-1 of each row).
// Ports   : none (package).
package car_dash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Widest pattern the helper can describe; callers truncate to ROWS*SEG_W.
  localparam int MAX_W = 1024;

  function automatic logic [MAX_W-1:0] wall_mask(input int seg_w, input int rows);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int r = 0; r < rows; r++) begin
      m = m | (MAX_W'(1) << (r * seg_w)) | (MAX_W'(1) << (r * seg_w + seg_w - 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
//
// Purpose : Advances every non-reset cycle using LFSR_MASK feedback.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset, loads seed
//           seed - reset value; zero is replaced by 16'h0001 (all-zero locks up)
//           q    - current LFSR state
module lfsr16 import car_dash_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;
  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

  always_comb begin
    q_d = q_q >> 1;
    if (q_q[0]) begin
      q_d = (q_q >> 1) ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= seed_eff;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_seq_gen.sv
// rtl/obstacle_seq_gen.sv - random obstacle row-pattern generator with walls and a guaranteed free lane
//
// Purpose : On step, builds a ROWS x SEG_W obstacle pattern from walls plus
//           up to NOBS random placements per row (one per cycle), then
//           publishes it on seq with a one-cycle valid pulse.
// Ports   : clk   - clock
//           rst   - synchronous active-high reset
//           step  - request a new pattern (one-deep queue while busy)
//           level - (only with OBSTACLE_SEQ_LEVEL_EN) extra attempts per row
//           seq   - current pattern, row r at seq[r*SEG_W +: SEG_W]
//           valid - pulses in the cycle seq takes a new value
//           busy  - high while a generation is in progress
// Config  : OBSTACLE_SEQ_LEVEL_EN adds the level input.
module obstacle_seq_gen import car_dash_pkg::*; #(
  parameter int          SEG_W = 8,
  parameter int          ROWS  = 2,
  parameter int          NOBS  = 3,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
`ifdef OBSTACLE_SEQ_LEVEL_EN
  input  logic [1:0]            level,
`endif
  output logic [ROWS*SEG_W-1:0] seq,
  output logic                  valid,
  output logic                  busy
);

  localparam int                W        = ROWS * SEG_W;
  localparam int                PW       = $clog2(SEG_W);
  localparam logic [W-1:0]      WALLS    = W'(wall_mask(SEG_W, ROWS));
  localparam logic [SEG_W-1:0]  ROW_ONES = '1;
  localparam logic [SEG_W-1:0]  ONE      = {{(SEG_W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic           pending_q, pending_d;
  logic [W-1:0]   build_q, build_d;
  logic [W-1:0]   seq_q, seq_d;
  logic           valid_q, valid_d;
  logic [31:0]    row_q, row_d;
  logic [31:0]    col_q, col_d;
  logic [31:0]    apr;
  logic [31:0]    shamt;
  logic [SEG_W-1:0] row_bits, cand;
  logic           last_attempt;
  logic           start_gen;
  logic [15:0]    lfsr_q;
  logic           unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Only the low PW bits pick a cell; the rest just keep the sequence long.
  assign unused_lfsr_bits = ^lfsr_q[15:PW];

`ifdef OBSTACLE_SEQ_LEVEL_EN
  logic [31:0] apr_q, apr_d, apr_next;

  always_comb begin
    apr_next = 32'(NOBS) + {30'd0, level};
    if (apr_next > 32'(SEG_W - 2)) begin
      apr_next = 32'(SEG_W - 2);
    end
    apr_d = start_gen ? apr_next : apr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      apr_q <= 32'(NOBS);
    end else begin
      apr_q <= apr_d;
    end
  end

  assign apr = apr_q;
`else
  assign apr = 32'(NOBS);
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A step arriving in DONE itself counts as pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (step) state_d = ST_GEN;
      ST_GEN:  if (last_attempt) state_d = ST_DONE;
      ST_DONE: state_d = (pending_q || step) ? ST_GEN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = (state_q != ST_IDLE);
    valid = valid_q;
    seq   = seq_q;
  end

  assign last_attempt = (row_q == 32'(ROWS - 1)) && (col_q == apr - 32'd1);
  assign start_gen    = (state_d == ST_GEN) && (state_q != ST_GEN);

  // Current row slice and the candidate with the new cell set. Wall or
  // already-set hits leave cand equal to row_bits, so the write is a no-op.
  assign shamt    = row_q * SEG_W;
  assign row_bits = SEG_W'(build_q >> shamt);
  assign cand     = row_bits | (ONE << lfsr_q[PW-1:0]);

  always_comb begin
    build_d   = build_q;
    row_d     = row_q;
    col_d     = col_q;
    seq_d     = seq_q;
    valid_d   = 1'b0;
    pending_d = pending_q;

    if (start_gen) begin
      build_d = WALLS;
      row_d   = 32'd0;
      col_d   = 32'd0;
    end else if (state_q == ST_GEN) begin
      // Never fill a row completely: keep at least one open lane.
      if (cand != ROW_ONES) begin
        build_d = (build_q & ~(W'(ROW_ONES) << shamt)) | (W'(cand) << shamt);
      end
      if (col_q == apr - 32'd1) begin
        col_d = 32'd0;
        row_d = row_q + 32'd1;
      end else begin
        col_d = col_q + 32'd1;
      end
    end

    if (state_q == ST_DONE) begin
      seq_d   = build_q;
      valid_d = 1'b1;
    end

    case (state_q)
      ST_GEN:  pending_d = pending_q | step;
      ST_DONE: pending_d = 1'b0;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      build_q   <= WALLS;
      seq_q     <= WALLS;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      row_q     <= 32'd0;
      col_q     <= 32'd0;
    end else begin
      build_q   <= build_d;
      seq_q     <= seq_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

endmodule

// File: tb/tb_obstacle_seq_gen.sv
// tb/tb_obstacle_seq_gen.sv - directed self-checking bench for obstacle_seq_gen
module tb_obstacle_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, step_a, step_b, step_c;
  logic [15:0] seq_a, seq_b, seq_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;

  int tests = 0;
  int fails = 0;

  logic [15:0] lfsr_m, lfsr_z;
  logic [15:0] last_a;

  obstacle_seq_gen u_dut (
    .clk(clk), .rst(rst), .step(step_a),
`ifdef OBSTACLE_SEQ_LEVEL_EN
    .level(2'd0),
`endif
    .seq(seq_a), .valid(valid_a), .busy(busy_a)
  );

  obstacle_seq_gen #(.NOBS(7)) u_dut7 (
    .clk(clk), .rst(rst), .step(step_b),
`ifdef OBSTACLE_SEQ_LEVEL_EN
    .level(2'd0),
`endif
    .seq(seq_b), .valid(valid_b), .busy(busy_b)
  );

  obstacle_seq_gen #(.SEED(16'h0000)) u_dutz (
    .clk(clk), .rst(rst), .step(step_c),
`ifdef OBSTACLE_SEQ_LEVEL_EN
    .level(2'd0),
`endif
    .seq(seq_c), .valid(valid_c), .busy(busy_c)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference pattern for SEG_W=8, ROWS=2 starting from the LFSR value seen
  // in the first GEN cycle.
  function automatic logic [15:0] model_pattern(input logic [15:0] start, input int nobs);
    logic [15:0] b;
    logic [15:0] s;
    logic [7:0]  row;
    logic [7:0]  nr;
    int          r;
    int          p;
    b = 16'h8181;
    s = start;
    for (int a = 0; a < 2 * nobs; a++) begin
      r   = a / nobs;
      p   = int'(s[2:0]);
      row = b[r*8 +: 8];
      nr  = row | (8'd1 << p);
      if (nr != 8'hFF) b[r*8 +: 8] = nr;
      s = lfsr_next(s);
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      lfsr_m <= 16'hACE1;
      lfsr_z <= 16'h0001;
    end else begin
      lfsr_m <= lfsr_next(lfsr_m);
      lfsr_z <= lfsr_next(lfsr_z);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; step_a = 1'b1; step_b = 1'b0; step_c = 1'b0;
    tick();
    tick();
    tests++;
    if (seq_a !== 16'h8181) begin fails++; $display("FAIL reset_seq got %h want 8181", seq_a); end
    tests++;
    if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_a); end
    tests++;
    if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
    tests++;
    if (seq_c !== 16'h8181) begin fails++; $display("FAIL reset_seq_seed0 got %h want 8181", seq_c); end
    rst = 1'b0; step_a = 1'b0;
    last_a = 16'h8181;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (seq_a !== 16'h8181 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
        fails++;
        $display("FAIL idle cyc %0d got seq=%h valid=%b busy=%b want 8181/0/0", i, seq_a, valid_a, busy_a);
      end
    end
  endtask

  task automatic test_single_step;
    logic [15:0] snap, e, want_seq;
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    snap = lfsr_m;
    e = model_pattern(snap, 3);
    tests++;
    if (busy_a !== 1'b1) begin fails++; $display("FAIL step_busy got %b want 1", busy_a); end
    for (int j = 1; j <= 12; j++) begin
      tick();
      tests++;
      if (valid_a !== (j == 7)) begin
        fails++; $display("FAIL single_valid j=%0d got %b want %b", j, valid_a, (j == 7));
      end
      tests++;
      if (busy_a !== (j < 7)) begin
        fails++; $display("FAIL single_busy j=%0d got %b want %b", j, busy_a, (j < 7));
      end
      want_seq = (j >= 7) ? e : last_a;
      tests++;
      if (seq_a !== want_seq) begin
        fails++; $display("FAIL single_seq j=%0d got %h want %h", j, seq_a, want_seq);
      end
      if (j == 7) begin
        tests++;
        if ((seq_a & 16'h8181) !== 16'h8181) begin
          fails++; $display("FAIL single_walls got %h want walls 8181 set", seq_a);
        end
      end
    end
    last_a = e;
  endtask

  task automatic test_back_to_back;
    logic [15:0] snap1, snap2, e1, e2, want_seq;
    int vcount;
    vcount = 0;
    e2 = 16'h0000;
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    snap1 = lfsr_m;
    e1 = model_pattern(snap1, 3);
    for (int j = 1; j <= 18; j++) begin
      step_a = (j == 2 || j == 3);
      tick();
      step_a = 1'b0;
      if (j == 7) begin
        snap2 = lfsr_m;
        e2 = model_pattern(snap2, 3);
      end
      if (valid_a === 1'b1) vcount++;
      tests++;
      if (valid_a !== (j == 7 || j == 14)) begin
        fails++; $display("FAIL b2b_valid j=%0d got %b want %b", j, valid_a, (j == 7 || j == 14));
      end
      tests++;
      if (busy_a !== (j < 14)) begin
        fails++; $display("FAIL b2b_busy j=%0d got %b want %b", j, busy_a, (j < 14));
      end
      want_seq = (j < 7) ? last_a : ((j < 14) ? e1 : e2);
      tests++;
      if (seq_a !== want_seq) begin
        fails++; $display("FAIL b2b_seq j=%0d got %h want %h", j, seq_a, want_seq);
      end
    end
    tests++;
    if (vcount != 2) begin fails++; $display("FAIL b2b_pulses got %0d want 2", vcount); end
    last_a = e2;
  endtask

  task automatic test_reset_abort;
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    for (int j = 1; j <= 3; j++) tick();
    rst = 1'b1;
    step_a = 1'b1;
    tick();
    rst = 1'b0;
    step_a = 1'b0;
    tests++;
    if (seq_a !== 16'h8181) begin fails++; $display("FAIL abort_seq got %h want 8181", seq_a); end
    tests++;
    if (busy_a !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy_a); end
    for (int j = 0; j < 12; j++) begin
      tick();
      tests++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
        fails++; $display("FAIL abort_quiet j=%0d got valid=%b busy=%b want 0/0", j, valid_a, busy_a);
      end
    end
    last_a = 16'h8181;
  endtask

  task automatic test_seed_zero;
    logic [15:0] snap, e;
    int seen;
    seen = 0;
    step_c = 1'b1;
    tick();
    step_c = 1'b0;
    snap = lfsr_z;
    e = model_pattern(snap, 3);
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (valid_c === 1'b1 && seen == 0) seen = j;
    end
    tests++;
    if (seen != 7) begin fails++; $display("FAIL seed0_latency got %0d want 7", seen); end
    tests++;
    if (seq_c !== e) begin fails++; $display("FAIL seed0_seq got %h want %h", seq_c, e); end
  endtask

  task automatic test_free_lane;
    logic [15:0] snap, e;
    int seen;
    for (int n = 0; n < 1000; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      step_b = 1'b1;
      tick();
      step_b = 1'b0;
      snap = lfsr_m;
      e = model_pattern(snap, 7);
      seen = 0;
      for (int j = 1; j <= 20 && seen == 0; j++) begin
        tick();
        if (valid_b === 1'b1) seen = j;
      end
      tests++;
      if (seen != 15) begin fails++; $display("FAIL lane_latency n=%0d got %0d want 15", n, seen); end
      tests++;
      if (seq_b !== e) begin fails++; $display("FAIL lane_seq n=%0d got %h want %h", n, seq_b, e); end
      tests++;
      if (seq_b[7:0] === 8'hFF || seq_b[15:8] === 8'hFF) begin
        fails++; $display("FAIL lane_open n=%0d got %h want a zero in each row", n, seq_b);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; step_a = 1'b0; step_b = 1'b0; step_c = 1'b0;
    last_a = 16'h8181;
    #1;
    test_reset();
    test_idle();
    test_single_step();
    test_back_to_back();
    test_reset_abort();
    test_seed_zero();
    test_free_lane();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
